// File: rtl/ref_req_pkg.sv
// rtl/ref_req_pkg.sv - shared FSM state, request struct and defaults for the block request generator
package ref_req_pkg;

  localparam int COORD_WDTH_DEF = 12;
  localparam int DIM_WDTH_DEF   = 7;
  localparam int NUM_CH_DEF     = 2;
  localparam int MAX_OUTST_DEF  = 4;

  // Request fields are sized for the widest supported configuration; users cast to their widths.
  localparam int REQ_CW  = 16;
  localparam int REQ_DW  = 16;
  localparam int REQ_CHW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [REQ_CW-1:0]  x;
    logic [REQ_CW-1:0]  y;
    logic [REQ_DW-1:0]  w;
    logic [REQ_DW-1:0]  h;
    logic [REQ_CHW-1:0] ch;
  } req_t;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ref_req_tile_walker.sv
// rtl/ref_req_tile_walker.sv - tile coordinate stepping, serpentine direction and edge clipping
module ref_req_tile_walker
  import ref_req_pkg::*;
#(
  parameter int COORD_WDTH = COORD_WDTH_DEF,
  parameter int DIM_WDTH   = DIM_WDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [COORD_WDTH-1:0] pic_width,
  input  logic [COORD_WDTH-1:0] pic_height,
  input  logic [DIM_WDTH-1:0]   blk_w,
  input  logic [DIM_WDTH-1:0]   blk_h,
  input  logic                  serp,
  output logic [COORD_WDTH-1:0] tile_x,
  output logic [COORD_WDTH-1:0] tile_y,
  output logic [DIM_WDTH-1:0]   tile_w,
  output logic [DIM_WDTH-1:0]   tile_h,
  output logic                  last_tile
);

  logic [COORD_WDTH-1:0] x_q, y_q, pw_q, ph_q;
  logic [DIM_WDTH-1:0]   bw_q, bh_q;
  logic                  serp_q, rtl_q;
  logic [COORD_WDTH:0]   x_end, y_end;
  logic [COORD_WDTH-1:0] rem_w, rem_h;
  logic                  row_end, last_row, next_rtl;

  assign x_end    = {1'b0, x_q} + (COORD_WDTH+1)'(bw_q);
  assign y_end    = {1'b0, y_q} + (COORD_WDTH+1)'(bh_q);
  assign row_end  = rtl_q ? (x_q == '0) : (x_end >= {1'b0, pw_q});
  assign last_row = (y_end >= {1'b0, ph_q});
  assign last_tile = row_end && last_row;
  // A right-to-left row begins where the preceding left-to-right row ended, so x is simply held.
  assign next_rtl = serp_q && !rtl_q;

  assign rem_w  = pw_q - x_q;
  assign rem_h  = ph_q - y_q;
  assign tile_x = x_q;
  assign tile_y = y_q;
  assign tile_w = (rem_w < COORD_WDTH'(bw_q)) ? DIM_WDTH'(rem_w) : bw_q;
  assign tile_h = (rem_h < COORD_WDTH'(bh_q)) ? DIM_WDTH'(rem_h) : bh_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      pw_q   <= '0;
      ph_q   <= '0;
      bw_q   <= '0;
      bh_q   <= '0;
      serp_q <= 1'b0;
      rtl_q  <= 1'b0;
    end else if (load) begin
      x_q    <= '0;
      y_q    <= '0;
      pw_q   <= pic_width;
      ph_q   <= pic_height;
      bw_q   <= blk_w;
      bh_q   <= blk_h;
      serp_q <= serp;
      rtl_q  <= 1'b0;
    end else if (step && !last_tile) begin
      if (row_end) begin
        y_q   <= y_end[COORD_WDTH-1:0];
        rtl_q <= next_rtl;
        if (!next_rtl) x_q <= '0;
      end else if (rtl_q) begin
        x_q <= x_q - COORD_WDTH'(bw_q);
      end else begin
        x_q <= x_end[COORD_WDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/ref_block_req_gen.sv
// rtl/ref_block_req_gen.sv - reference block request generator; optional counters under REF_REQ_GEN_PERF_EN
module ref_block_req_gen
  import ref_req_pkg::*;
#(
  parameter int COORD_WDTH = COORD_WDTH_DEF,
  parameter int DIM_WDTH   = DIM_WDTH_DEF,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int MAX_OUTST  = MAX_OUTST_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_in,
  input  logic [COORD_WDTH-1:0]          pic_width_in,
  input  logic [COORD_WDTH-1:0]          pic_height_in,
  input  logic [DIM_WDTH-1:0]            blk_w_in,
  input  logic [DIM_WDTH-1:0]            blk_h_in,
  input  logic                           serp_in,
  output logic                           req_valid_out,
  input  logic                           req_ready_in,
  output logic signed [COORD_WDTH-1:0]   req_x_out,
  output logic signed [COORD_WDTH-1:0]   req_y_out,
  output logic [DIM_WDTH-1:0]            req_w_out,
  output logic [DIM_WDTH-1:0]            req_h_out,
  output logic [ch_bits(NUM_CH)-1:0]     req_ch_out,
  input  logic                           resp_valid_in,
  output logic                           busy_out,
  output logic                           done_out,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_out
`ifdef REF_REQ_GEN_PERF_EN
  ,
  output logic [31:0]                    perf_req_cnt_out,
  output logic [31:0]                    perf_stall_cnt_out
`endif
);

  localparam int CHW = ch_bits(NUM_CH);
  localparam int OW  = $clog2(MAX_OUTST+1);

  state_t                state_q, state_d;
  logic [CHW-1:0]        ch_q;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  start_ok, dims_ok, at_limit, xfer, last_ch, step, last_tile;
  logic [COORD_WDTH-1:0] tile_x, tile_y;
  logic [DIM_WDTH-1:0]   tile_w, tile_h;
  req_t                  req;

  assign start_ok = start_in && (state_q == ST_IDLE);
  assign dims_ok  = (|blk_w_in) && (|blk_h_in) && (|pic_width_in) && (|pic_height_in);
  assign at_limit = (outst_q == OW'(MAX_OUTST));
  assign req_valid_out = (state_q == ST_ISSUE) && !at_limit;
  assign xfer     = req_valid_out && req_ready_in;
  assign last_ch  = (ch_q == CHW'(NUM_CH-1));
  assign step     = xfer && last_ch;

  ref_req_tile_walker #(
    .COORD_WDTH(COORD_WDTH),
    .DIM_WDTH  (DIM_WDTH)
  ) u_walker (
    .clk       (clk),
    .reset     (reset),
    .load      (start_ok),
    .step      (step),
    .pic_width (pic_width_in),
    .pic_height(pic_height_in),
    .blk_w     (blk_w_in),
    .blk_h     (blk_h_in),
    .serp      (serp_in),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .tile_w    (tile_w),
    .tile_h    (tile_h),
    .last_tile (last_tile)
  );

  // Chroma 4:2:0 halves the luma tile, rounding sizes up so odd edges stay covered.
  always_comb begin
    req    = '0;
    req.ch = REQ_CHW'(ch_q);
    if (ch_q == '0) begin
      req.x = REQ_CW'(tile_x);
      req.y = REQ_CW'(tile_y);
      req.w = REQ_DW'(tile_w);
      req.h = REQ_DW'(tile_h);
    end else begin
      req.x = REQ_CW'(tile_x) >> 1;
      req.y = REQ_CW'(tile_y) >> 1;
      req.w = (REQ_DW'(tile_w) + REQ_DW'(1)) >> 1;
      req.h = (REQ_DW'(tile_h) + REQ_DW'(1)) >> 1;
    end
  end

  assign req_x_out  = $signed(COORD_WDTH'(req.x));
  assign req_y_out  = $signed(COORD_WDTH'(req.y));
  assign req_w_out  = DIM_WDTH'(req.w);
  assign req_h_out  = DIM_WDTH'(req.h);
  assign req_ch_out = CHW'(req.ch);

  always_comb begin
    outst_d = outst_q;
    if (xfer && !resp_valid_in) begin
      outst_d = outst_q + OW'(1);
    end else if (!xfer && resp_valid_in && (outst_q != '0)) begin
      outst_d = outst_q - OW'(1);
    end
  end

  // DRAIN looks at the next count so done follows the final response by one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_in) state_d = dims_ok ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if (step && last_tile) state_d = ST_DRAIN;
      ST_DRAIN: if (outst_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      outst_q <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (start_ok) begin
        ch_q <= '0;
      end else if (xfer) begin
        ch_q <= last_ch ? '0 : ch_q + CHW'(1);
      end
    end
  end

  assign busy_out  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done_out  = (state_q == ST_DONE);
  assign outst_out = outst_q;

`ifdef REF_REQ_GEN_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_req_cnt_out   <= '0;
      perf_stall_cnt_out <= '0;
    end else if (start_ok) begin
      perf_req_cnt_out   <= '0;
      perf_stall_cnt_out <= '0;
    end else begin
      if (xfer && !(&perf_req_cnt_out)) perf_req_cnt_out <= perf_req_cnt_out + 32'd1;
      if (req_valid_out && !req_ready_in && !(&perf_stall_cnt_out))
        perf_stall_cnt_out <= perf_stall_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ref_block_req_gen.sv
// tb/tb_ref_block_req_gen.sv - scoreboard bench for ref_block_req_gen against a tile-list reference model
module tb_ref_block_req_gen;

  localparam int CW   = 12;
  localparam int DW   = 7;
  localparam int NCH  = 2;
  localparam int MAXO = 4;
  localparam int OW   = $clog2(MAXO+1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start_in = 1'b0;
  logic [CW-1:0]        pic_width_in = '0, pic_height_in = '0;
  logic [DW-1:0]        blk_w_in = '0, blk_h_in = '0;
  logic                 serp_in = 1'b0;
  logic                 req_valid_out;
  logic                 req_ready = 1'b0;
  logic signed [CW-1:0] req_x, req_y;
  logic [DW-1:0]        req_w, req_h;
  logic [0:0]           req_ch;
  logic                 resp_valid = 1'b0;
  logic                 busy_out, done_out;
  logic [OW-1:0]        outst_out;
`ifdef REF_REQ_GEN_PERF_EN
  logic [31:0]          perf_req_cnt_out, perf_stall_cnt_out;
`endif

  always #5 clk = ~clk;

  ref_block_req_gen #(.COORD_WDTH(CW), .DIM_WDTH(DW), .NUM_CH(NCH), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset(reset), .start_in(start_in),
    .pic_width_in(pic_width_in), .pic_height_in(pic_height_in),
    .blk_w_in(blk_w_in), .blk_h_in(blk_h_in), .serp_in(serp_in),
    .req_valid_out(req_valid_out), .req_ready_in(req_ready),
    .req_x_out(req_x), .req_y_out(req_y), .req_w_out(req_w), .req_h_out(req_h),
    .req_ch_out(req_ch), .resp_valid_in(resp_valid),
    .busy_out(busy_out), .done_out(done_out), .outst_out(outst_out)
`ifdef REF_REQ_GEN_PERF_EN
    , .perf_req_cnt_out(perf_req_cnt_out), .perf_stall_cnt_out(perf_stall_cnt_out)
`endif
  );

  typedef struct {
    int x;
    int y;
    int w;
    int h;
    int ch;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0, errors = 0;
  int   mcnt = 0, xfer_cnt = 0, cyc = 0, zero_cyc = -10;
  int   done_seen = 0, done_base = 0;
  bit   mon_en = 1'b0, lat_chk = 1'b0, stalled = 1'b0;
  int   sx, sy, sw, sh, sch;
  int   ready_mode = 0, resp_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: enumerate tiles by row/column index, then derive luma and chroma fields.
  task automatic push_scan(input int w, input int h, input int bw, input int bh, input bit s,
                           output int n);
    int   nc, nr, col, x, y, tw, th;
    exp_t e;
    n = 0;
    if (w == 0 || h == 0 || bw == 0 || bh == 0) return;
    nc = (w + bw - 1) / bw;
    nr = (h + bh - 1) / bh;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        col = (s && (r % 2 == 1)) ? nc - 1 - c : c;
        x   = col * bw;
        y   = r * bh;
        tw  = (w - x < bw) ? w - x : bw;
        th  = (h - y < bh) ? h - y : bh;
        for (int ch = 0; ch < NCH; ch++) begin
          if (ch == 0) e = '{x, y, tw, th, 0};
          else         e = '{x / 2, y / 2, (tw + 1) / 2, (th + 1) / 2, ch};
          exp_q.push_back(e);
          n++;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       req_ready = 1'b1;
      1:       req_ready = ($urandom_range(0, 3) != 0);
      default: req_ready = 1'b0;
    endcase
    case (resp_mode)
      1:       resp_valid = (mcnt > 0);
      2:       resp_valid = (mcnt > 0) && ($urandom_range(0, 1) == 1);
      3: begin
        resp_valid = (mcnt > 0);
        resp_mode  = 0;
      end
      4:       resp_valid = 1'b1;
      default: resp_valid = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    bit   xf;
    cyc++;
    if (mon_en && !reset) begin
      chk("outst", int'(outst_out), mcnt);
      if (mcnt == MAXO) chk("valid_at_limit", int'(req_valid_out), 0);
      if (stalled && !req_valid_out) chk("valid_withdrawn", int'(req_valid_out), 1);
      if (req_valid_out) begin
        if (stalled) begin
          chk("hold_x", int'(req_x), sx);
          chk("hold_y", int'(req_y), sy);
          chk("hold_w", int'(req_w), sw);
          chk("hold_h", int'(req_h), sh);
          chk("hold_ch", int'(req_ch), sch);
        end
        if (req_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_req", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("req_x", int'(req_x), e.x);
            chk("req_y", int'(req_y), e.y);
            chk("req_w", int'(req_w), e.w);
            chk("req_h", int'(req_h), e.h);
            chk("req_ch", int'(req_ch), e.ch);
          end
          xfer_cnt++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sx = int'(req_x); sy = int'(req_y); sw = int'(req_w); sh = int'(req_h); sch = int'(req_ch);
        end
      end else begin
        stalled = 1'b0;
      end
      xf = req_valid_out && req_ready;
      if (xf && !resp_valid) begin
        mcnt++;
      end else if (!xf && resp_valid && mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) zero_cyc = cyc;
      end
      if (done_out) begin
        done_seen++;
        chk("done_drained", exp_q.size(), 0);
        if (lat_chk) chk("done_latency", cyc, zero_cyc + 1);
      end
    end
  end

  task automatic start_scan(input int w, input int h, input int bw, input int bh, input bit s,
                            output int n);
    push_scan(w, h, bw, bh, s, n);
    lat_chk   = (n > 0);
    done_base = done_seen;
    @(posedge clk); #2;
    start_in = 1'b1;
    pic_width_in = CW'(w); pic_height_in = CW'(h);
    blk_w_in = DW'(bw); blk_h_in = DW'(bh); serp_in = s;
    @(posedge clk); #2;
    start_in = 1'b0;
    pic_width_in = CW'($urandom); pic_height_in = CW'($urandom);
    blk_w_in = DW'($urandom); blk_h_in = DW'($urandom); serp_in = 1'($urandom);
    @(negedge clk); #1;
    if (n > 0) begin
      chk("first_valid", int'(req_valid_out), 1);
      chk("busy_issue", int'(busy_out), 1);
    end else begin
      chk("zero_done", int'(done_out), 1);
      chk("zero_busy", int'(busy_out), 0);
    end
  endtask

  task automatic wait_done();
    int i = 0;
    while (done_seen == done_base && i < 6000) begin
      @(negedge clk); #1;
      i++;
    end
    chk("done_reached", done_seen, done_base + 1);
    chk("scan_drained", exp_q.size(), 0);
    @(negedge clk); #1;
    chk("done_one_cycle", int'(done_out), 0);
    chk("idle_busy", int'(busy_out), 0);
  endtask

  initial begin
    int n, x0, w, h, bw, bh;
    #3;
    chk("rst_valid", int'(req_valid_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_outst", int'(outst_out), 0);
    chk("rst_x", int'(req_x), 0);
    chk("rst_w", int'(req_w), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    mon_en = 1'b1;

    resp_mode = 4;
    repeat (3) @(negedge clk);
    resp_mode = 0;
    repeat (2) @(negedge clk);

    resp_mode = 1;
    start_scan(16, 16, 8, 8, 1'b0, n); wait_done();
    start_scan(20, 12, 8, 8, 1'b1, n); wait_done();
    start_scan(8, 8, 8, 8, 1'b0, n);   wait_done();
    start_scan(10, 8, 10, 8, 1'b0, n); wait_done();
    start_scan(16, 16, 0, 8, 1'b0, n); wait_done();

    resp_mode = 0;
    x0 = xfer_cnt;
    start_scan(64, 8, 8, 8, 1'b0, n);
    repeat (10) @(negedge clk);
    #1;
    start_in = 1'b1; pic_width_in = 8; pic_height_in = 8; blk_w_in = 8; blk_h_in = 8;
    @(posedge clk); #2 start_in = 1'b0;
    @(negedge clk); #1;
    chk("limit_xfers", xfer_cnt - x0, MAXO);
    chk("limit_valid", int'(req_valid_out), 0);
    resp_mode = 3;
    repeat (6) @(negedge clk);
    #1 chk("one_more_xfer", xfer_cnt - x0, MAXO + 1);
    resp_mode = 1;
    wait_done();

    ready_mode = 2;
    start_scan(32, 8, 8, 8, 1'b0, n);
    repeat (4) @(negedge clk);
    ready_mode = 0;
    wait_done();
`ifdef REF_REQ_GEN_PERF_EN
    chk("perf_stall", int'(perf_stall_cnt_out), 5);
    chk("perf_req", int'(perf_req_cnt_out), n);
`endif

    ready_mode = 1;
    resp_mode  = 2;
    for (int t = 0; t < 6; t++) begin
      w  = $urandom_range(1, 40); h  = $urandom_range(1, 40);
      bw = $urandom_range(4, 16); bh = $urandom_range(4, 16);
      start_scan(w, h, bw, bh, 1'($urandom), n);
      wait_done();
`ifdef REF_REQ_GEN_PERF_EN
      chk("perf_req_rand", int'(perf_req_cnt_out), n);
`endif
    end

    ready_mode = 0;
    resp_mode  = 0;
    x0 = xfer_cnt;
    start_scan(64, 8, 8, 8, 1'b0, n);
    for (int i = 0; i < 20 && xfer_cnt - x0 < 2; i++) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("abort_valid", int'(req_valid_out), 0);
    chk("abort_busy", int'(busy_out), 0);
    chk("abort_outst", int'(outst_out), 0);
    chk("abort_x", int'(req_x), 0);
    chk("abort_w", int'(req_w), 0);
    mon_en = 1'b0;
    exp_q.delete();
    mcnt = 0;
    stalled = 1'b0;
    done_base = done_seen;
    @(posedge clk); #2 reset = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    #1 chk("abort_no_done", done_seen, done_base);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
